// File: rtl/fifomult_driver.sv
// Initiator for the fifomult2024 serial operand interface: sends parity-protected operand
// words, waits for the product, and returns product plus status over a response handshake.
module fifomult_driver #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [1:0]       req_bad_par,
  output logic [15:0]      mul_data,
  output logic             mul_data_parity,
  output logic             mul_data_valid,
  input  logic             mul_busy,
  input  logic [31:0]      mul_result,
  input  logic             mul_result_parity,
  input  logic             mul_result_valid,
  input  logic             mul_parity_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [2:0]       rsp_status,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    GAP,
    SEND_B,
    WAIT_RES,
    RESP
  } state_t;

  localparam logic [15:0]      TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  logic             r_req_ready;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [1:0]       r_bad_par;
  logic [15:0]      r_mul_data;
  logic             r_mul_parity;
  logic             r_mul_valid;
  logic [15:0]      r_timer;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic [2:0]       r_rsp_status;
  logic [CNT_W-1:0] r_txn_count;
  logic [CNT_W-1:0] r_err_count;

  state_t           w_next;
  logic             w_latch;
  logic [15:0]      w_mul_data;
  logic             w_mul_parity;
  logic             w_mul_valid;
  logic [15:0]      w_timer;
  logic             w_rsp_valid;
  logic [31:0]      w_rsp_data;
  logic [2:0]       w_rsp_status;
  logic [CNT_W-1:0] w_txn_count;
  logic [CNT_W-1:0] w_err_count;

  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_mul_data   = '0;
    w_mul_parity = 1'b0;
    w_mul_valid  = 1'b0;
    w_timer      = r_timer;
    w_rsp_valid  = r_rsp_valid;
    w_rsp_data   = r_rsp_data;
    w_rsp_status = r_rsp_status;
    w_txn_count  = r_txn_count;
    w_err_count  = r_err_count;
    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_latch = 1'b1;
          w_next  = SEND_A;
        end
      end
      SEND_A: begin
        if (!mul_busy) begin
          w_mul_data   = r_a;
          w_mul_parity = (^r_a) ^ r_bad_par[0];
          w_mul_valid  = 1'b1;
          w_next       = GAP;
        end
      end
      GAP: begin
        w_next = SEND_B;
      end
      SEND_B: begin
        if (!mul_busy) begin
          w_mul_data   = r_b;
          w_mul_parity = (^r_b) ^ r_bad_par[1];
          w_mul_valid  = 1'b1;
          w_timer      = '0;
          w_next       = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A result arriving on the timeout cycle takes priority over the abort
        if (mul_result_valid) begin
          w_rsp_valid  = 1'b1;
          w_rsp_data   = mul_result;
          w_rsp_status = {1'b0, mul_parity_error, (^mul_result) ^ mul_result_parity};
          w_next       = RESP;
        end else if (r_timer == TIMER_LAST) begin
          w_rsp_valid  = 1'b1;
          w_rsp_data   = '0;
          w_rsp_status = 3'b100;
          w_next       = RESP;
        end else begin
          w_timer = r_timer + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          if (r_txn_count != '1) w_txn_count = r_txn_count + CNT_ONE;
          if ((r_rsp_status != 3'b000) && (r_err_count != '1)) w_err_count = r_err_count + CNT_ONE;
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_bad_par    <= '0;
      r_mul_data   <= '0;
      r_mul_parity <= 1'b0;
      r_mul_valid  <= 1'b0;
      r_timer      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
      r_txn_count  <= '0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_next;
      r_req_ready  <= (w_next == IDLE);
      if (w_latch) begin
        r_a       <= req_a;
        r_b       <= req_b;
        r_bad_par <= req_bad_par;
      end
      r_mul_data   <= w_mul_data;
      r_mul_parity <= w_mul_parity;
      r_mul_valid  <= w_mul_valid;
      r_timer      <= w_timer;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_data   <= w_rsp_data;
      r_rsp_status <= w_rsp_status;
      r_txn_count  <= w_txn_count;
      r_err_count  <= w_err_count;
    end
  end

  assign req_ready       = r_req_ready;
  assign mul_data        = r_mul_data;
  assign mul_data_parity = r_mul_parity;
  assign mul_data_valid  = r_mul_valid;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign rsp_status      = r_rsp_status;
  assign txn_count       = r_txn_count;
  assign err_count       = r_err_count;

endmodule
